rv32i_alu: RTL and testbench
============================

Name: rv32i_alu

Overview:
- Execute stage of the 5-stage RV32I core, between decode and memory-access.
- Selects operands and performs the one-hot-selected arithmetic, logic, shift or compare operation.
- Resolves branches and jumps into a PC redirect and computes the rd writeback value.
- Registers everything into the execute/memory pipeline register, honouring stall, force-stall and flush.

Parameters:
- ALU_WIDTH, 14, one-hot op vector: bit0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 XOR, 5 OR, 6 AND, 7 SLL, 8 SRL, 9 SRA, 10 EQ, 11 NEQ, 12 GE, 13 GEU.
- OPCODE_WIDTH, 11, one-hot: bit0 RTYPE, 1 ITYPE, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 SYSTEM, 10 FENCE.
- EXCEPTION_WIDTH, 4, one-hot: bit0 ILLEGAL, 1 ECALL, 2 EBREAK, 3 MRET.

Ports:
- i_clk in 1 clock
- i_rst_n in 1 reset
- i_alu in ALU_WIDTH: op select
- i_rs1_addr in 5; i_rs1, i_rs2 in 32 each: source operands
- i_imm in 32: sign-extended immediate
- i_funct3 in 3; i_opcode in OPCODE_WIDTH; i_exception in EXCEPTION_WIDTH
- i_pc in 32; i_rd_addr in 5
- i_ce in 1: stage input valid
- i_stall, i_force_stall, i_flush in 1 each
- o_rs1_addr out 5; o_rs1, o_rs2 out 32 each: registered pass-through
- o_imm out 12: i_imm[11:0], the CSR index
- o_funct3 out 3; o_opcode out OPCODE_WIDTH; o_exception out EXCEPTION_WIDTH: registered pass-through
- o_y out 32: ALU result
- o_pc out 32; o_next_pc out 32: redirect target
- o_change_pc out 1
- o_wr_rd out 1; o_rd_addr out 5; o_rd out 32; o_rd_valid out 1
- o_stall_from_alu out 1: load/store stall to the memory stage
- o_ce out 1; o_stall out 1; o_flush out 1

Interface: one clock, i_clk. Reset i_rst_n is asynchronous, active-low.

Behaviour:
- Operand A = i_pc if JAL or AUIPC, else i_rs1. Operand B = i_rs2 if RTYPE or BRANCH, else i_imm.
- Combinational result y_d:
  - ADD a+b; SUB a-b, 32-bit wrap.
  - SLT signed a<b; SLTU unsigned a<b.
  - XOR, OR, AND bitwise.
  - SLL, SRL, SRA shift by b[4:0].
  - EQ, NEQ, GE signed, GEU unsigned.
  - Compare results are 0/1 in bit0, upper bits 0. All-zero i_alu gives y_d=0.
- Redirect:
  - Branch taken when BRANCH and y_d[0]=1. Target = i_pc+i_imm.
  - JAL target = i_pc+i_imm. JALR target = (i_rs1+i_imm) & ~1.
- rd value:
  - JAL/JALR: i_pc+4. LUI: i_imm. Otherwise y_d (AUIPC yields pc+imm).
- wr_rd = 0 for BRANCH, STORE, FENCE, and SYSTEM with funct3=0; 1 otherwise.
- rd_valid = wr_rd AND NOT (LOAD or SYSTEM), because those results resolve later.
- Combinational outputs:
  - o_stall = (i_stall | i_force_stall) & ~i_flush. o_flush = i_flush.
  - stall_bit = o_stall | i_stall.
- Clocked, when i_ce & ~stall_bit (one-cycle latency):
  - Register all pass-throughs, o_y=y_d, o_rd, o_wr_rd, o_rd_valid, o_pc, o_next_pc.
  - o_change_pc = taken|JAL|JALR. o_stall_from_alu = LOAD|STORE.
- o_ce next state:
  - i_flush & ~stall_bit: o_ce=0.
  - Else if ~stall_bit: o_ce=i_ce.
  - Else if stall_bit & ~i_stall (force-stall only): o_ce=0, a bubble.
  - Else o_ce holds.
- o_change_pc, o_stall_from_alu: cleared on any non-stalled clock with i_ce=0 or i_flush=1; held while stalled. A redirect therefore pulses for exactly one cycle per accepted jump.
- Simultaneous flush and input: flush wins; o_ce=0 and o_change_pc=0, data registers may update.
- Reset: every registered output is 0, with no clock required. Reset mid-operation discards the in-flight instruction.

Test Plan:
- Reset: i_rst_n=0 -> all registered outputs 0, including o_ce=0 and o_change_pc=0. Release with i_ce=1 and stalls low -> o_ce=1 after one clock.
- RTYPE SUB, rs1=5, rs2=7 -> o_y=0xFFFFFFFE, o_rd=0xFFFFFFFE, o_wr_rd=1, o_rd_valid=1. ITYPE SRA, rs1=0x80000000, imm=4 -> o_y=0xF8000000.
- BRANCH NEQ, rs1=1, rs2=2, pc=0x100, imm=0x20 -> o_change_pc=1 for one cycle, o_next_pc=0x120, o_wr_rd=0. Same with rs2=1 -> o_change_pc=0.
- JALR, rs1=0x1001, imm=4, pc=0x40 -> o_next_pc=0x1004, o_rd=0x44, o_change_pc=1. AUIPC, pc=0x1000, imm=0x2000 -> o_rd=0x3000.
- LOAD, rs1=0x10, imm=8 -> o_y=0x18, o_stall_from_alu=1, o_rd_valid=0, o_wr_rd=1.
- Pipeline control:
  - i_stall=1 -> registered outputs hold and o_stall=1.
  - i_force_stall alone -> o_ce drops to 0.
  - i_flush with a JAL -> o_ce=0, o_change_pc=0, o_stall=0.

Source files
------------

// File: rtl/rv32i_alu_if.sv
// Decode <-> execute bundle for the RV32I execute stage.
// The slave side is the execute stage itself; the master side is whatever
// drives it (the decode stage, or a testbench).
interface rv32i_alu_if #(
    parameter int ALU_WIDTH       = 14,
    parameter int OPCODE_WIDTH    = 11,
    parameter int EXCEPTION_WIDTH = 4
);
    // Inputs from decode
    logic [ALU_WIDTH-1:0]       i_alu;
    logic [4:0]                 i_rs1_addr;
    logic [31:0]                i_rs1;
    logic [31:0]                i_rs2;
    logic [31:0]                i_imm;
    logic [2:0]                 i_funct3;
    logic [OPCODE_WIDTH-1:0]    i_opcode;
    logic [EXCEPTION_WIDTH-1:0] i_exception;
    logic [31:0]                i_pc;
    logic [4:0]                 i_rd_addr;
    logic                       i_ce;
    logic                       i_stall;
    logic                       i_force_stall;
    logic                       i_flush;

    // Execute/memory pipeline register and stage control
    logic [4:0]                 o_rs1_addr;
    logic [31:0]                o_rs1;
    logic [31:0]                o_rs2;
    logic [11:0]                o_imm;
    logic [2:0]                 o_funct3;
    logic [OPCODE_WIDTH-1:0]    o_opcode;
    logic [EXCEPTION_WIDTH-1:0] o_exception;
    logic [31:0]                o_y;
    logic [31:0]                o_pc;
    logic [31:0]                o_next_pc;
    logic                       o_change_pc;
    logic                       o_wr_rd;
    logic [4:0]                 o_rd_addr;
    logic [31:0]                o_rd;
    logic                       o_rd_valid;
    logic                       o_stall_from_alu;
    logic                       o_ce;
    logic                       o_stall;
    logic                       o_flush;

    modport master (
        output i_alu, i_rs1_addr, i_rs1, i_rs2, i_imm, i_funct3, i_opcode,
               i_exception, i_pc, i_rd_addr, i_ce, i_stall, i_force_stall, i_flush,
        input  o_rs1_addr, o_rs1, o_rs2, o_imm, o_funct3, o_opcode, o_exception,
               o_y, o_pc, o_next_pc, o_change_pc, o_wr_rd, o_rd_addr, o_rd,
               o_rd_valid, o_stall_from_alu, o_ce, o_stall, o_flush
    );

    modport slave (
        input  i_alu, i_rs1_addr, i_rs1, i_rs2, i_imm, i_funct3, i_opcode,
               i_exception, i_pc, i_rd_addr, i_ce, i_stall, i_force_stall, i_flush,
        output o_rs1_addr, o_rs1, o_rs2, o_imm, o_funct3, o_opcode, o_exception,
               o_y, o_pc, o_next_pc, o_change_pc, o_wr_rd, o_rd_addr, o_rd,
               o_rd_valid, o_stall_from_alu, o_ce, o_stall, o_flush
    );
endinterface

// File: rtl/rv32i_alu.sv
// RV32I execute stage: operand selection, one-hot ALU, branch/jump
// resolution, rd writeback value, and the execute/memory pipeline register
// with stall, force-stall (bubble insertion) and flush handling.
module rv32i_alu #(
    parameter int ALU_WIDTH       = 14,
    parameter int OPCODE_WIDTH    = 11,
    parameter int EXCEPTION_WIDTH = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    rv32i_alu_if.slave    bus
);
    // One-hot ALU operation bit positions
    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_SLT  = 2;
    localparam int OP_SLTU = 3;
    localparam int OP_XOR  = 4;
    localparam int OP_OR   = 5;
    localparam int OP_AND  = 6;
    localparam int OP_SLL  = 7;
    localparam int OP_SRL  = 8;
    localparam int OP_SRA  = 9;
    localparam int OP_EQ   = 10;
    localparam int OP_NEQ  = 11;
    localparam int OP_GE   = 12;
    localparam int OP_GEU  = 13;

    // One-hot opcode bit positions (only those that steer logic here)
    localparam int OPC_RTYPE  = 0;
    localparam int OPC_LOAD   = 2;
    localparam int OPC_STORE  = 3;
    localparam int OPC_BRANCH = 4;
    localparam int OPC_JAL    = 5;
    localparam int OPC_JALR   = 6;
    localparam int OPC_LUI    = 7;
    localparam int OPC_AUIPC  = 8;
    localparam int OPC_SYSTEM = 9;
    localparam int OPC_FENCE  = 10;

    // Compare outputs are a single flag in bit 0
    function automatic logic [31:0] flag32(input logic b);
        return {31'd0, b};
    endfunction

    // Decoded opcode flags
    logic is_rtype, is_load, is_store, is_branch, is_jal, is_jalr;
    logic is_lui, is_auipc, is_system, is_fence;

    assign is_rtype  = bus.i_opcode[OPC_RTYPE];
    assign is_load   = bus.i_opcode[OPC_LOAD];
    assign is_store  = bus.i_opcode[OPC_STORE];
    assign is_branch = bus.i_opcode[OPC_BRANCH];
    assign is_jal    = bus.i_opcode[OPC_JAL];
    assign is_jalr   = bus.i_opcode[OPC_JALR];
    assign is_lui    = bus.i_opcode[OPC_LUI];
    assign is_auipc  = bus.i_opcode[OPC_AUIPC];
    assign is_system = bus.i_opcode[OPC_SYSTEM];
    assign is_fence  = bus.i_opcode[OPC_FENCE];

    // Operands: PC-relative ops use the PC, register/branch ops use rs2
    logic        [31:0] a_op;
    logic        [31:0] b_op;
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic        [4:0]  shamt;

    assign a_op  = (is_jal | is_auipc)   ? bus.i_pc  : bus.i_rs1;
    assign b_op  = (is_rtype | is_branch) ? bus.i_rs2 : bus.i_imm;
    assign a_s   = a_op;
    assign b_s   = b_op;
    assign shamt = b_op[4:0];

    // Next-state values for the pipeline register
    logic [31:0] y_d;
    logic [31:0] rd_d;
    logic [31:0] next_pc_d;
    logic        taken_d;
    logic        change_pc_d;
    logic        wr_rd_d;
    logic        rd_valid_d;
    logic        stall_from_alu_d;

    // ALU: the op vector is one-hot, so OR-ing the selected terms gives the result
    always_comb begin
        y_d = '0;
        if (bus.i_alu[OP_ADD])  y_d |= a_op + b_op;
        if (bus.i_alu[OP_SUB])  y_d |= a_op - b_op;
        if (bus.i_alu[OP_SLT])  y_d |= flag32(a_s < b_s);
        if (bus.i_alu[OP_SLTU]) y_d |= flag32(a_op < b_op);
        if (bus.i_alu[OP_XOR])  y_d |= a_op ^ b_op;
        if (bus.i_alu[OP_OR])   y_d |= a_op | b_op;
        if (bus.i_alu[OP_AND])  y_d |= a_op & b_op;
        if (bus.i_alu[OP_SLL])  y_d |= a_op << shamt;
        if (bus.i_alu[OP_SRL])  y_d |= a_op >> shamt;
        if (bus.i_alu[OP_SRA])  y_d |= 32'(a_s >>> shamt);
        if (bus.i_alu[OP_EQ])   y_d |= flag32(a_op == b_op);
        if (bus.i_alu[OP_NEQ])  y_d |= flag32(a_op != b_op);
        if (bus.i_alu[OP_GE])   y_d |= flag32(a_s >= b_s);
        if (bus.i_alu[OP_GEU])  y_d |= flag32(a_op >= b_op);
    end

    // Redirect, writeback value and writeback qualifiers
    always_comb begin
        taken_d     = is_branch & y_d[0];
        change_pc_d = taken_d | is_jal | is_jalr;
        // JALR clears bit 0 of the target; branches and JAL are PC-relative
        next_pc_d   = is_jalr ? ((bus.i_rs1 + bus.i_imm) & ~32'd1)
                              : (bus.i_pc + bus.i_imm);
        if (is_jal | is_jalr) begin
            rd_d = bus.i_pc + 32'd4;
        end else if (is_lui) begin
            rd_d = bus.i_imm;
        end else begin
            rd_d = y_d;
        end
        // CSR ops (SYSTEM with funct3!=0) write rd; ECALL/EBREAK/MRET do not
        wr_rd_d = ~(is_branch | is_store | is_fence |
                    (is_system & (bus.i_funct3 == 3'd0)));
        // Load and CSR results are only known in a later stage
        rd_valid_d       = wr_rd_d & ~(is_load | is_system);
        stall_from_alu_d = is_load | is_store;
    end

    // Stage control
    logic stall_o;
    logic stall_bit;
    logic accept;

    assign stall_o       = (bus.i_stall | bus.i_force_stall) & ~bus.i_flush;
    assign stall_bit     = stall_o | bus.i_stall;
    assign accept        = bus.i_ce & ~stall_bit;
    assign bus.o_stall   = stall_o;
    assign bus.o_flush   = bus.i_flush;

    // Pipeline register contents
    logic [4:0]                 rs1_addr_q;
    logic [31:0]                rs1_q;
    logic [31:0]                rs2_q;
    logic [11:0]                imm_q;
    logic [2:0]                 funct3_q;
    logic [OPCODE_WIDTH-1:0]    opcode_q;
    logic [EXCEPTION_WIDTH-1:0] exception_q;
    logic [31:0]                y_q;
    logic [31:0]                pc_q;
    logic [31:0]                next_pc_q;
    logic                       wr_rd_q;
    logic [4:0]                 rd_addr_q;
    logic [31:0]                rd_q;
    logic                       rd_valid_q;
    logic                       change_pc_q;
    logic                       stall_from_alu_q;
    logic                       ce_q;

    // Data register: captures the instruction whenever the stage accepts one
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rs1_addr_q  <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            funct3_q    <= '0;
            opcode_q    <= '0;
            exception_q <= '0;
            y_q         <= '0;
            pc_q        <= '0;
            next_pc_q   <= '0;
            wr_rd_q     <= 1'b0;
            rd_addr_q   <= '0;
            rd_q        <= '0;
            rd_valid_q  <= 1'b0;
        end else if (accept) begin
            rs1_addr_q  <= bus.i_rs1_addr;
            rs1_q       <= bus.i_rs1;
            rs2_q       <= bus.i_rs2;
            imm_q       <= bus.i_imm[11:0];
            funct3_q    <= bus.i_funct3;
            opcode_q    <= bus.i_opcode;
            exception_q <= bus.i_exception;
            y_q         <= y_d;
            pc_q        <= bus.i_pc;
            next_pc_q   <= next_pc_d;
            wr_rd_q     <= wr_rd_d;
            rd_addr_q   <= bus.i_rd_addr;
            rd_q        <= rd_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    // Control register: valid, redirect pulse and memory-stage stall request
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ce_q             <= 1'b0;
            change_pc_q      <= 1'b0;
            stall_from_alu_q <= 1'b0;
        end else if (!stall_bit) begin
            // Flush squashes the incoming instruction's side effects
            ce_q             <= bus.i_ce & ~bus.i_flush;
            change_pc_q      <= bus.i_ce & ~bus.i_flush & change_pc_d;
            stall_from_alu_q <= bus.i_ce & ~bus.i_flush & stall_from_alu_d;
        end else if (!bus.i_stall) begin
            // Force-stall only: emit a bubble downstream
            ce_q             <= 1'b0;
        end
    end

    assign bus.o_rs1_addr       = rs1_addr_q;
    assign bus.o_rs1            = rs1_q;
    assign bus.o_rs2            = rs2_q;
    assign bus.o_imm            = imm_q;
    assign bus.o_funct3         = funct3_q;
    assign bus.o_opcode         = opcode_q;
    assign bus.o_exception      = exception_q;
    assign bus.o_y              = y_q;
    assign bus.o_pc             = pc_q;
    assign bus.o_next_pc        = next_pc_q;
    assign bus.o_change_pc      = change_pc_q;
    assign bus.o_wr_rd          = wr_rd_q;
    assign bus.o_rd_addr        = rd_addr_q;
    assign bus.o_rd             = rd_q;
    assign bus.o_rd_valid       = rd_valid_q;
    assign bus.o_stall_from_alu = stall_from_alu_q;
    assign bus.o_ce             = ce_q;
endmodule

// File: tb/tb_rv32i_alu.sv
// Self-checking bench for the RV32I execute stage: directed cases followed by
// randomized instructions and pipeline-control traffic against a reference model.
module tb_rv32i_alu;
    localparam int OP_ADD = 0, OP_SUB = 1, OP_SLT = 2, OP_SLTU = 3, OP_XOR = 4;
    localparam int OP_OR = 5, OP_AND = 6, OP_SLL = 7, OP_SRL = 8, OP_SRA = 9;
    localparam int OP_EQ = 10, OP_NEQ = 11, OP_GE = 12, OP_GEU = 13;
    localparam int RTYPE = 0, ITYPE = 1, LOAD = 2, STORE = 3, BRANCH = 4, JAL = 5;
    localparam int JALR = 6, LUI = 7, AUIPC = 8, SYSTEM = 9, FENCE = 10;

    typedef struct packed {
        logic [13:0] alu;
        logic [4:0]  rs1_addr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [2:0]  funct3;
        logic [10:0] opcode;
        logic [3:0]  exception;
        logic [31:0] pc;
        logic [4:0]  rd_addr;
        logic        ce;
        logic        stall;
        logic        fstall;
        logic        flush;
    } in_t;

    typedef struct packed {
        logic [4:0]  rs1_addr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [11:0] imm;
        logic [2:0]  funct3;
        logic [10:0] opcode;
        logic [3:0]  exception;
        logic [31:0] y;
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic        wr_rd;
        logic [4:0]  rd_addr;
        logic [31:0] rd;
        logic        rd_valid;
        logic        change_pc;
        logic        stall_from_alu;
        logic        ce;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rv32i_alu_if bus ();
    rv32i_alu dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    int   n_vec = 0;
    int   n_err = 0;
    exp_t m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference ALU computed with plain integer arithmetic
    function automatic logic [31:0] ref_alu(input logic [13:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        int          sa;
        int          sb;
        int unsigned sh;
        r  = '0;
        sa = int'(a);
        sb = int'(b);
        sh = int'(b) & 31;
        for (int k = 0; k < 14; k++) begin
            if (op[k]) begin
                case (k)
                    OP_ADD:  r |= 32'(sa + sb);
                    OP_SUB:  r |= 32'(sa - sb);
                    OP_SLT:  r |= (sa < sb) ? 32'd1 : 32'd0;
                    OP_SLTU: r |= (a < b) ? 32'd1 : 32'd0;
                    OP_XOR:  r |= a ^ b;
                    OP_OR:   r |= a | b;
                    OP_AND:  r |= a & b;
                    OP_SLL:  r |= a << sh;
                    OP_SRL:  r |= a >> sh;
                    OP_SRA:  r |= 32'(sa >>> sh);
                    OP_EQ:   r |= (a == b) ? 32'd1 : 32'd0;
                    OP_NEQ:  r |= (a != b) ? 32'd1 : 32'd0;
                    OP_GE:   r |= (sa >= sb) ? 32'd1 : 32'd0;
                    OP_GEU:  r |= (a >= b) ? 32'd1 : 32'd0;
                    default: ;
                endcase
            end
        end
        return r;
    endfunction

    // Next pipeline-register state from the current state and the inputs
    function automatic exp_t model_next(input exp_t c, input in_t v);
        exp_t        n;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        stalled;
        logic        redirect;
        logic        wr;
        logic        live;
        n        = c;
        stalled  = v.stall || (v.fstall && !v.flush);
        a        = (v.opcode[JAL] || v.opcode[AUIPC]) ? v.pc : v.rs1;
        b        = (v.opcode[RTYPE] || v.opcode[BRANCH]) ? v.rs2 : v.imm;
        y        = ref_alu(v.alu, a, b);
        redirect = (v.opcode[BRANCH] && y[0]) || v.opcode[JAL] || v.opcode[JALR];
        wr       = !(v.opcode[BRANCH] || v.opcode[STORE] || v.opcode[FENCE] ||
                     (v.opcode[SYSTEM] && v.funct3 == 3'd0));
        if (!stalled && v.ce) begin
            n.rs1_addr  = v.rs1_addr;
            n.rs1       = v.rs1;
            n.rs2       = v.rs2;
            n.imm       = v.imm[11:0];
            n.funct3    = v.funct3;
            n.opcode    = v.opcode;
            n.exception = v.exception;
            n.y         = y;
            n.pc        = v.pc;
            n.next_pc   = v.opcode[JALR] ? ((v.rs1 + v.imm) & 32'hFFFF_FFFE) : (v.pc + v.imm);
            n.wr_rd     = wr;
            n.rd_addr   = v.rd_addr;
            n.rd        = (v.opcode[JAL] || v.opcode[JALR]) ? v.pc + 32'd4 :
                          v.opcode[LUI] ? v.imm : y;
            n.rd_valid  = wr && !(v.opcode[LOAD] || v.opcode[SYSTEM]);
        end
        live = v.ce && !v.flush;
        if (!stalled) begin
            n.ce             = live;
            n.change_pc      = live && redirect;
            n.stall_from_alu = live && (v.opcode[LOAD] || v.opcode[STORE]);
        end else if (!v.stall) begin
            n.ce = 1'b0;
        end
        return n;
    endfunction

    task automatic check_state(input string w);
        check({w, ".rs1_addr"},  32'(bus.o_rs1_addr),       32'(m.rs1_addr));
        check({w, ".rs1"},       bus.o_rs1,                 m.rs1);
        check({w, ".rs2"},       bus.o_rs2,                 m.rs2);
        check({w, ".imm"},       32'(bus.o_imm),            32'(m.imm));
        check({w, ".funct3"},    32'(bus.o_funct3),         32'(m.funct3));
        check({w, ".opcode"},    32'(bus.o_opcode),         32'(m.opcode));
        check({w, ".exception"}, 32'(bus.o_exception),      32'(m.exception));
        check({w, ".y"},         bus.o_y,                   m.y);
        check({w, ".pc"},        bus.o_pc,                  m.pc);
        check({w, ".next_pc"},   bus.o_next_pc,             m.next_pc);
        check({w, ".wr_rd"},     32'(bus.o_wr_rd),          32'(m.wr_rd));
        check({w, ".rd_addr"},   32'(bus.o_rd_addr),        32'(m.rd_addr));
        check({w, ".rd"},        bus.o_rd,                  m.rd);
        check({w, ".rd_valid"},  32'(bus.o_rd_valid),       32'(m.rd_valid));
        check({w, ".change_pc"}, 32'(bus.o_change_pc),      32'(m.change_pc));
        check({w, ".sfa"},       32'(bus.o_stall_from_alu), 32'(m.stall_from_alu));
        check({w, ".ce"},        32'(bus.o_ce),             32'(m.ce));
    endtask

    task automatic drive(input in_t v);
        bus.i_alu         = v.alu;
        bus.i_rs1_addr    = v.rs1_addr;
        bus.i_rs1         = v.rs1;
        bus.i_rs2         = v.rs2;
        bus.i_imm         = v.imm;
        bus.i_funct3      = v.funct3;
        bus.i_opcode      = v.opcode;
        bus.i_exception   = v.exception;
        bus.i_pc          = v.pc;
        bus.i_rd_addr     = v.rd_addr;
        bus.i_ce          = v.ce;
        bus.i_stall       = v.stall;
        bus.i_force_stall = v.fstall;
        bus.i_flush       = v.flush;
    endtask

    // Drive one cycle, check the combinational outputs, clock, check the register
    task automatic apply(input string w, input in_t v);
        drive(v);
        #1;
        check({w, ".o_stall"}, 32'(bus.o_stall), 32'((v.stall | v.fstall) & ~v.flush));
        check({w, ".o_flush"}, 32'(bus.o_flush), 32'(v.flush));
        m = model_next(m, v);
        @(posedge clk);
        #1;
        check_state(w);
    endtask

    function automatic in_t mk(input int opc, input int op, input logic [31:0] rs1,
                               input logic [31:0] rs2, input logic [31:0] imm,
                               input logic [31:0] pc);
        in_t v;
        v = '0;
        v.opcode[opc] = 1'b1;
        if (op >= 0) v.alu[op] = 1'b1;
        v.rs1      = rs1;
        v.rs2      = rs2;
        v.imm      = imm;
        v.pc       = pc;
        v.rs1_addr = 5'd1;
        v.rd_addr  = 5'd3;
        v.funct3   = 3'd1;
        v.ce       = 1'b1;
        return v;
    endfunction

    function automatic in_t rand_instr();
        in_t         v;
        logic [31:0] r;
        v           = '0;
        v.opcode    = 11'(1) << $urandom_range(0, 10);
        v.alu       = ($urandom_range(0, 15) == 0) ? 14'd0 : 14'(1) << $urandom_range(0, 13);
        v.rs1       = $urandom;
        v.rs2       = ($urandom_range(0, 3) == 0) ? v.rs1 : $urandom;
        r           = $urandom;
        v.imm       = ($urandom_range(0, 1) == 0) ? {{20{r[11]}}, r[11:0]} : r;
        v.funct3    = 3'($urandom_range(0, 7));
        v.exception = 4'(1) << $urandom_range(0, 4);
        v.pc        = $urandom & 32'hFFFF_FFFC;
        v.rs1_addr  = 5'($urandom_range(0, 31));
        v.rd_addr   = 5'($urandom_range(0, 31));
        v.ce        = ($urandom_range(0, 3) != 0);
        v.stall     = ($urandom_range(0, 7) == 0);
        v.fstall    = ($urandom_range(0, 7) == 0);
        v.flush     = ($urandom_range(0, 9) == 0);
        return v;
    endfunction

    initial begin
        in_t v;
        rst_n = 1'b1;
        v = '0;
        drive(v);
        m = '0;
        #2 rst_n = 1'b0;
        #2;
        m = '0;
        check_state("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        v = mk(RTYPE, OP_SUB, 32'd5, 32'd7, 32'd0, 32'd0);
        apply("sub", v);
        check("sub.ce_after_reset", 32'(bus.o_ce), 32'd1);
        check("sub.y_const", bus.o_y, 32'hFFFF_FFFE);
        check("sub.rd_const", bus.o_rd, 32'hFFFF_FFFE);
        check("sub.wr_valid", {30'd0, bus.o_wr_rd, bus.o_rd_valid}, 32'd3);

        v = mk(ITYPE, OP_SRA, 32'h8000_0000, 32'd0, 32'd4, 32'd0);
        apply("sra", v);
        check("sra.y_const", bus.o_y, 32'hF800_0000);

        v = mk(BRANCH, OP_NEQ, 32'd1, 32'd2, 32'h20, 32'h100);
        apply("bne_taken", v);
        check("bne.change_const", 32'(bus.o_change_pc), 32'd1);
        check("bne.next_pc_const", bus.o_next_pc, 32'h120);
        check("bne.wr_const", 32'(bus.o_wr_rd), 32'd0);
        v.ce = 1'b0;
        apply("bne_pulse_end", v);
        check("bne.pulse_one_cycle", 32'(bus.o_change_pc), 32'd0);
        v = mk(BRANCH, OP_NEQ, 32'd1, 32'd1, 32'h20, 32'h100);
        apply("bne_not_taken", v);
        check("bne_nt.change_const", 32'(bus.o_change_pc), 32'd0);

        v = mk(JALR, OP_ADD, 32'h1001, 32'd0, 32'd4, 32'h40);
        apply("jalr", v);
        check("jalr.next_pc_const", bus.o_next_pc, 32'h1004);
        check("jalr.rd_const", bus.o_rd, 32'h44);
        check("jalr.change_const", 32'(bus.o_change_pc), 32'd1);

        v = mk(AUIPC, OP_ADD, 32'h5555, 32'd0, 32'h2000, 32'h1000);
        apply("auipc", v);
        check("auipc.rd_const", bus.o_rd, 32'h3000);

        v = mk(LUI, -1, 32'h0, 32'd0, 32'hABCD_E000, 32'h10);
        apply("lui", v);
        check("lui.rd_const", bus.o_rd, 32'hABCD_E000);
        check("lui.y_zero_op", bus.o_y, 32'd0);

        v = mk(LOAD, OP_ADD, 32'h10, 32'd0, 32'd8, 32'h0);
        apply("load", v);
        check("load.y_const", bus.o_y, 32'h18);
        check("load.sfa_const", 32'(bus.o_stall_from_alu), 32'd1);
        check("load.rd_valid_const", 32'(bus.o_rd_valid), 32'd0);
        check("load.wr_const", 32'(bus.o_wr_rd), 32'd1);

        v = mk(RTYPE, OP_ADD, 32'd1, 32'd1, 32'd0, 32'h0);
        v.stall = 1'b1;
        apply("stall", v);
        check("stall.o_stall_const", 32'(bus.o_stall), 32'd1);
        check("stall.y_held", bus.o_y, 32'h18);
        check("stall.ce_held", 32'(bus.o_ce), 32'd1);

        v.stall  = 1'b0;
        v.fstall = 1'b1;
        apply("force_stall", v);
        check("fstall.ce_bubble", 32'(bus.o_ce), 32'd0);

        v = mk(JAL, OP_ADD, 32'd0, 32'd0, 32'h80, 32'h200);
        v.flush = 1'b1;
        apply("flush_jal", v);
        check("flush.ce_const", 32'(bus.o_ce), 32'd0);
        check("flush.change_const", 32'(bus.o_change_pc), 32'd0);
        check("flush.o_stall_const", 32'(bus.o_stall), 32'd0);

        for (int i = 0; i < 400; i++) begin
            v = rand_instr();
            apply("rand", v);
        end

        v = mk(JAL, OP_ADD, 32'd0, 32'd0, 32'h40, 32'h300);
        apply("pre_reset_jal", v);
        check("pre_reset.change_const", 32'(bus.o_change_pc), 32'd1);
        drive(rand_instr());
        #2 rst_n = 1'b0;
        #1;
        m = '0;
        check_state("mid_reset");
        #3 rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
